// File: rtl/glb_stream_arb_pkg.sv
// Shared widths, channel count and per-channel FSM state for the two-channel
// memory-to-stream arbiter.
package glb_stream_pkg;
  localparam int DATA_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 10;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int NCH            = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } ch_state_e;
endpackage

// File: rtl/glb_stream_arb_if.sv
// Shared-memory read port plus both output streams; master is the arbiter side.
interface glb_stream_arb_if
  import glb_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] data_0, data_1;
  logic              valid_0, valid_1;
  logic              ready_0, ready_1;

  modport master (
    output mem_rd_en, mem_rd_addr, data_0, data_1, valid_0, valid_1,
    input  mem_rd_data, ready_0, ready_1
  );
  modport slave (
    input  mem_rd_en, mem_rd_addr, data_0, data_1, valid_0, valid_1,
    output mem_rd_data, ready_0, ready_1
  );
endinterface

// File: rtl/glb_stream_arb_fifo.sv
// Small synchronous FIFO with occupancy count; head reads as zero when empty.
module glb_stream_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [DATA_W-1:0]            din_i,
  input  logic                         pop_i,
  output logic [DATA_W-1:0]            dout_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     cnt_q;
  logic              do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (cnt_q != CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign empty_o = (cnt_q == '0);
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/glb_stream_arb.sv
// Two DMA-style channels share one single-port memory through a round-robin
// arbiter; each channel streams its words in order through a local FIFO.
module glb_stream_arb
  import glb_stream_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              cfg_en_0,
  input  logic              cfg_en_1,
  input  logic [ADDR_W-1:0] cfg_base_0,
  input  logic [ADDR_W-1:0] cfg_base_1,
  input  logic [ADDR_W:0]   cfg_len_0,
  input  logic [ADDR_W:0]   cfg_len_1,
  output logic              done_0,
  output logic              done_1,
  glb_stream_arb_if.master  bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  ch_state_e state_q [NCH];
  ch_state_e state_d [NCH];

  logic [NCH-1:0][ADDR_W-1:0] cfg_base, base_q, base_d;
  logic [NCH-1:0][ADDR_W:0]   cfg_len, len_q, len_d, iss_q, iss_d;
  logic [NCH-1:0][CW-1:0]     cnt;
  logic [NCH-1:0][DATA_W-1:0] dout;
  logic [NCH-1:0]             cfg_en, ready, elig, gnt, push, pop, empty;
  logic                       gnt_id, prio_q, prio_d, rd_vld_q, rd_id_q;

  assign cfg_en   = {cfg_en_1, cfg_en_0};
  assign cfg_base = {cfg_base_1, cfg_base_0};
  assign cfg_len  = {cfg_len_1, cfg_len_0};
  assign ready    = {bus.ready_1, bus.ready_0};

  // push doubles as the in-flight flag: the returning word lands this cycle.
  always_comb begin
    for (int c = 0; c < NCH; c++)
      elig[c] = (state_q[c] == ST_RUN) &&
                ((int'(cnt[c]) + int'(push[c])) < FIFO_DEPTH);
  end

  always_comb begin
    gnt = '0;
    if (elig[prio_q])       gnt[prio_q]  = 1'b1;
    else if (elig[~prio_q]) gnt[~prio_q] = 1'b1;
  end

  assign gnt_id          = gnt[1];
  assign prio_d          = (|gnt) ? ~gnt_id : prio_q;
  assign bus.mem_rd_en   = |gnt;
  assign bus.mem_rd_addr = (|gnt) ? base_q[gnt_id] + iss_q[gnt_id][ADDR_W-1:0] : '0;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      state_d[c] = state_q[c];
      base_d[c]  = base_q[c];
      len_d[c]   = len_q[c];
      iss_d[c]   = iss_q[c];
      case (state_q[c])
        ST_IDLE, ST_DONE: begin
          if (flush && cfg_en[c]) begin
            base_d[c]  = cfg_base[c];
            len_d[c]   = cfg_len[c];
            iss_d[c]   = '0;
            state_d[c] = (cfg_len[c] != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          if (gnt[c]) begin
            iss_d[c] = iss_q[c] + (ADDR_W+1)'(1);
            if (iss_d[c] == len_q[c]) state_d[c] = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (empty[c] && !push[c]) state_d[c] = ST_DONE;
        end
        default: state_d[c] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) state_q[c] <= ST_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      iss_q    <= '0;
      prio_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_id_q  <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) state_q[c] <= state_d[c];
      base_q   <= base_d;
      len_q    <= len_d;
      iss_q    <= iss_d;
      prio_q   <= prio_d;
      rd_vld_q <= |gnt;
      rd_id_q  <= gnt_id;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign push[g] = rd_vld_q && (rd_id_q == 1'(g));
    assign pop[g]  = ~empty[g] & ready[g];
    glb_stream_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[g]),
      .din_i   (bus.mem_rd_data),
      .pop_i   (pop[g]),
      .dout_o  (dout[g]),
      .empty_o (empty[g]),
      .count_o (cnt[g])
    );
  end

  assign bus.data_0  = dout[0];
  assign bus.data_1  = dout[1];
  assign bus.valid_0 = ~empty[0];
  assign bus.valid_1 = ~empty[1];
  assign done_0      = (state_q[0] == ST_DONE);
  assign done_1      = (state_q[1] == ST_DONE);
endmodule
